// File: rtl/zero_gen.sv
// zero_gen: builds a one-hot word whose count of zeros, taken from the MSB side
// (LEFT_CNT=1) or from the LSB side (LEFT_CNT=0), equals a requested count.
// The word is streamed out MSB-first over DATA_WIDTH cycles. It is then
// presented in parallel on a valid/ready handshake.
module zero_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int ZERO_WIDTH = $clog2(DATA_WIDTH + 1),
  parameter bit LEFT_CNT   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ZERO_WIDTH-1:0] zero_num,
  output logic                  ser_valid,
  output logic                  ser_bit,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  err
);

  // Bit counter sized to index one serial cycle out of DATA_WIDTH.
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0]   word_reg, word_next;
  logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
  logic                    err_reg, err_next;

  // Decoded form of the incoming request. It is used only on the accept edge.
  logic [DATA_WIDTH-1:0]   word_calc;
  logic                    err_calc;
  logic [31:0]             k_ext;

  assign k_ext = 32'(zero_num);

  // A count of DATA_WIDTH or more matches no bit position, so the word
  // comes out as all zeros. Only a count strictly beyond DATA_WIDTH is an error.
  assign err_calc = (k_ext > 32'(DATA_WIDTH));

  // Each word bit is set only when the request selects its position.
  // For the MSB side, position 0 is the top bit.
  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_word_bit
      localparam int POS = LEFT_CNT ? (DATA_WIDTH - 1 - gi) : gi;
      assign word_calc[gi] = (k_ext == 32'(POS));
    end
  endgenerate

  // State and datapath registers. Reset clears everything so that an aborted
  // transaction leaves no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      word_reg  <= '0;
      shift_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      word_reg  <= word_next;
      shift_reg <= shift_next;
      err_reg   <= err_next;
    end
  end

  // Next-state logic and output decode. Outputs depend only on the state and
  // the registers, except where the handshake inputs steer transitions.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    word_next  = word_reg;
    shift_next = shift_reg;
    err_next   = err_reg;

    in_ready   = 1'b0;
    ser_valid  = 1'b0;
    ser_bit    = 1'b0;
    out_valid  = 1'b0;
    data       = '0;
    err        = 1'b0;

    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = SHIFT;
          cnt_next   = '0;
          word_next  = word_calc;
          shift_next = word_calc;
          err_next   = err_calc;
        end
      end

      SHIFT: begin
        ser_valid  = 1'b1;
        ser_bit    = shift_reg[DATA_WIDTH-1];
        shift_next = shift_reg << 1;
        if (cnt_reg == CNT_LAST) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        data      = word_reg;
        err       = err_reg;
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_zero_gen.sv
// Testbench for zero_gen. One instance counts zeros from the MSB side and one
// counts them from the LSB side. Every transaction is checked against a
// behavioural model of the generated word.
module tb_zero_gen;

  localparam int DW = 16;
  localparam int ZW = 5;

  logic clk;
  logic rst_n;

  // Index 1: LEFT_CNT=1 instance. Index 0: LEFT_CNT=0 instance.
  logic [1:0]         iv;
  logic [1:0][ZW-1:0] zn;
  logic [1:0]         ordy;
  logic [1:0]         ir;
  logic [1:0]         sv;
  logic [1:0]         sb;
  logic [1:0]         ov;
  logic [1:0][DW-1:0] dd;
  logic [1:0]         ee;

  int checks = 0;
  int errors = 0;

  zero_gen #(.DATA_WIDTH(DW), .ZERO_WIDTH(ZW), .LEFT_CNT(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]), .zero_num(zn[1]),
    .ser_valid(sv[1]), .ser_bit(sb[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .data(dd[1]), .err(ee[1])
  );

  zero_gen #(.DATA_WIDTH(DW), .ZERO_WIDTH(ZW), .LEFT_CNT(1'b0)) dut_r (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]), .zero_num(zn[0]),
    .ser_valid(sv[0]), .ser_bit(sb[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .data(dd[0]), .err(ee[0])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net: the directed sequence is far shorter than this limit.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Reference word: a single one placed k positions in from the counting side.
  // It is all zeros when k reaches the word width.
  function automatic logic [DW-1:0] model_word(input int side, input int k);
    logic [DW-1:0] w;
    w = '0;
    if (k < DW) begin
      if (side == 1) w[DW-1-k] = 1'b1;
      else           w[k]      = 1'b1;
    end
    return w;
  endfunction

  // Count zeros from the counting side until the first one.
  function automatic int lead_zeros(input int side, input logic [DW-1:0] w);
    int n;
    n = 0;
    for (int i = 0; i < DW; i++) begin
      if (side == 1) begin
        if (w[DW-1-i]) return n;
      end else begin
        if (w[i]) return n;
      end
      n++;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("%s_in_ready%0d", tag, s),  32'(ir[s]), 32'd1);
      chk($sformatf("%s_ser_valid%0d", tag, s), 32'(sv[s]), 32'd0);
      chk($sformatf("%s_ser_bit%0d", tag, s),   32'(sb[s]), 32'd0);
      chk($sformatf("%s_out_valid%0d", tag, s), 32'(ov[s]), 32'd0);
      chk($sformatf("%s_data%0d", tag, s),      32'(dd[s]), 32'd0);
      chk($sformatf("%s_err%0d", tag, s),       32'(ee[s]), 32'd0);
    end
  endtask

  // One full transaction. Inputs are driven 1 time unit after the rising
  // edge, and outputs are sampled at that same point. hold sets the number
  // of DONE cycles with out_ready low. noise makes the bench pulse in_valid
  // with junk while the block is busy.
  task automatic do_txn(input int side, input int k, input int hold, input bit noise);
    logic [DW-1:0] exp_w;
    logic          exp_e;
    logic [DW-1:0] got_w;
    exp_w = model_word(side, k);
    exp_e = (k > DW);

    chk($sformatf("idle_in_ready s%0d k%0d", side, k), 32'(ir[side]), 32'd1);
    chk($sformatf("idle_data s%0d k%0d", side, k), 32'(dd[side]), 32'd0);
    iv[side] = 1'b1;
    zn[side] = ZW'(k);
    @(posedge clk); #1;
    iv[side] = 1'b0;

    for (int j = 0; j < DW; j++) begin
      chk($sformatf("ser_valid s%0d k%0d j%0d", side, k, j), 32'(sv[side]), 32'd1);
      chk($sformatf("ser_bit s%0d k%0d j%0d", side, k, j), 32'(sb[side]), 32'(exp_w[DW-1-j]));
      chk($sformatf("shift_in_ready s%0d k%0d j%0d", side, k, j), 32'(ir[side]), 32'd0);
      chk($sformatf("shift_out_valid s%0d k%0d j%0d", side, k, j), 32'(ov[side]), 32'd0);
      if (noise) begin
        iv[side] = 1'($urandom_range(0, 1));
        zn[side] = ZW'($urandom_range(0, 31));
      end
      @(posedge clk); #1;
    end

    for (int h = 0; h < hold; h++) begin
      chk($sformatf("hold_out_valid s%0d k%0d h%0d", side, k, h), 32'(ov[side]), 32'd1);
      chk($sformatf("hold_data s%0d k%0d h%0d", side, k, h), 32'(dd[side]), 32'(exp_w));
      chk($sformatf("hold_err s%0d k%0d h%0d", side, k, h), 32'(ee[side]), 32'(exp_e));
      chk($sformatf("hold_in_ready s%0d k%0d h%0d", side, k, h), 32'(ir[side]), 32'd0);
      chk($sformatf("hold_ser_valid s%0d k%0d h%0d", side, k, h), 32'(sv[side]), 32'd0);
      if (noise) begin
        iv[side] = 1'($urandom_range(0, 1));
        zn[side] = ZW'($urandom_range(0, 31));
      end
      @(posedge clk); #1;
    end

    iv[side] = 1'b0;
    chk($sformatf("done_out_valid s%0d k%0d", side, k), 32'(ov[side]), 32'd1);
    chk($sformatf("done_data s%0d k%0d", side, k), 32'(dd[side]), 32'(exp_w));
    chk($sformatf("done_err s%0d k%0d", side, k), 32'(ee[side]), 32'(exp_e));
    chk($sformatf("done_ser_bit s%0d k%0d", side, k), 32'(sb[side]), 32'd0);
    got_w = dd[side];
    if (!exp_e) begin
      chk($sformatf("round_trip s%0d k%0d", side, k), 32'(lead_zeros(side, got_w)), 32'(k));
    end
    ordy[side] = 1'b1;
    @(posedge clk); #1;
    ordy[side] = 1'b0;
    chk($sformatf("after_out_valid s%0d k%0d", side, k), 32'(ov[side]), 32'd0);
    chk($sformatf("after_data s%0d k%0d", side, k), 32'(dd[side]), 32'd0);
    chk($sformatf("after_in_ready s%0d k%0d", side, k), 32'(ir[side]), 32'd1);
    $display("txn side=%0d zero_num=%0d hold=%0d data=%04h err=%0b", side, k, hold, got_w, ee[side]);
  endtask

  initial begin
    int side_r;
    int k_r;
    int hold_r;

    rst_n = 1'b0;
    iv    = '0;
    zn    = '0;
    ordy  = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Accept a request on the first edge after reset release.
    do_txn(1, 3, 0, 1'b0);             // data 16'h1000
    do_txn(0, 0, 0, 1'b0);             // data 16'h0001
    do_txn(0, 15, 1, 1'b0);            // data 16'h8000
    do_txn(0, 16, 0, 1'b0);            // all zeros, no error
    do_txn(1, 16, 0, 1'b0);            // all zeros, no error
    do_txn(1, 17, 0, 1'b0);            // all zeros, error
    do_txn(1, 31, 2, 1'b0);            // all zeros, error
    do_txn(1, 0, 10, 1'b1);            // long stall with ignored requests
    do_txn(0, 7, 10, 1'b1);

    // Abort at serial cycle 5.
    iv[1] = 1'b1;
    zn[1] = ZW'(5);
    @(posedge clk); #1;
    iv[1] = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("pre_abort_ser_valid", 32'(sv[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    @(posedge clk); #1;
    chk_reset_outputs("abort_hold");
    rst_n = 1'b1;
    do_txn(1, 0, 0, 1'b0);             // data 16'h8000

    // Random sweep over both counting sides, with random consumer stalls.
    for (int n = 0; n < 40; n++) begin
      side_r = int'($urandom_range(0, 1));
      k_r    = int'($urandom_range(0, 16));
      hold_r = int'($urandom_range(0, 3));
      do_txn(side_r, k_r, hold_r, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/zero_gen.md
ZERO_GEN -- requirements
Module: zero_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of the generated word.
REQ-002 SHALL have parameter ZERO_WIDTH, default $clog2(DATA_WIDTH+1), width of the zero count.
REQ-003 SHALL have parameter LEFT_CNT, default 1: 1 = zeros counted from MSB, 0 = zeros counted from LSB.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  zero_num is valid this cycle.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 zero_num  input  ZERO_WIDTH  requested count of leading zeros (MSB side if LEFT_CNT=1, LSB side otherwise).
REQ-009 ser_valid  output  1  ser_bit is valid this cycle.
REQ-010 ser_bit  output  1  serial copy of the generated word, MSB first.
REQ-011 out_valid  output  1  data and err are valid.
REQ-012 out_ready  input  1  consumer accepts data.
REQ-013 data  output  DATA_WIDTH  generated word.
REQ-014 err  output  1  captured zero_num exceeded DATA_WIDTH.

Function
REQ-015 SHALL implement a 3-state FSM: IDLE, SHIFT, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; in_ready SHALL be combinational from state only, not from in_valid.
REQ-017 IDLE -> SHIFT when in_valid && in_ready; zero_num is captured on that edge.
REQ-018 Generated word for LEFT_CNT=1, k = captured zero_num with k < DATA_WIDTH: bits [DATA_WIDTH-1 : DATA_WIDTH-k] = 0, bit DATA_WIDTH-1-k = 1, all lower bits = 0.
REQ-019 Generated word for LEFT_CNT=0, k < DATA_WIDTH: bits [k-1:0] = 0, bit k = 1, all higher bits = 0.
REQ-020 k == DATA_WIDTH: word SHALL be all zeros, err = 0.
REQ-021 k > DATA_WIDTH: word SHALL be all zeros, err = 1; the sequence otherwise runs normally.
REQ-022 SHIFT SHALL last exactly DATA_WIDTH cycles, driven by an internal bit counter; ser_valid = 1 in every SHIFT cycle and 0 otherwise.
REQ-023 In SHIFT cycle j (j = 0..DATA_WIDTH-1), ser_bit SHALL equal word bit DATA_WIDTH-1-j; ser_bit = 0 whenever ser_valid = 0.
REQ-024 SHIFT -> DONE after the last serial bit; serial output has no backpressure.
REQ-025 In DONE, out_valid = 1 and data/err SHALL hold stable until out_valid && out_ready.
REQ-026 DONE -> IDLE on out_ready; in_ready rises in the following cycle, giving a minimum request-to-request period of DATA_WIDTH+2 cycles.
REQ-027 data SHALL read 0 whenever out_valid = 0.
REQ-028 in_valid asserted outside IDLE SHALL be ignored and SHALL NOT alter captured state.
REQ-029 Round-trip property: for err = 0, the number of leading zeros of data (on the LEFT_CNT side) SHALL equal the captured zero_num.

Reset
REQ-030 While rst_n = 0: state = IDLE, bit counter = 0, in_ready = 1, ser_valid = 0, ser_bit = 0, out_valid = 0, data = 0, err = 0.
REQ-031 Reset asserted mid-SHIFT or mid-DONE SHALL abort the transaction immediately with no partial output after release.
REQ-032 The first request SHALL be accepted on the first clock edge after rst_n deasserts.

Verification
REQ-033 DATA_WIDTH=16, LEFT_CNT=1, zero_num=3 -> ser_bit stream 0,0,0,1 then 12 zeros over 16 ser_valid cycles; then data=16'h1000, err=0, out_valid=1.
REQ-034 LEFT_CNT=0, zero_num=0 -> data=16'h0001; zero_num=15 -> data=16'h8000; zero_num=16 -> data=16'h0000, err=0.
REQ-035 LEFT_CNT=1, zero_num=17 (max 5-bit value 31) -> data=16'h0000, err=1, full 16-cycle serial stream of zeros.
REQ-036 Hold out_ready=0 for 10 cycles in DONE -> out_valid and data stay stable, in_ready stays 0, and in_valid pulses are ignored; after out_ready=1, in_ready rises one cycle later.
REQ-037 Assert rst_n=0 at SHIFT cycle 5 -> all outputs go to their reset values at once; after release, a new request with zero_num=0 yields data=16'h8000.
REQ-038 Random sweep of zero_num 0..16 for both LEFT_CNT values, with random out_ready -> the leading-zero count of data equals zero_num in every transaction.
